pipereg: RTL and testbench
==========================

PIPEREG -- requirements
Module: pipereg

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, width of the datapath payload (ALU result, store data, addresses concatenated).
REQ-002 SHALL have parameter CWIDTH, default 8, width of the control payload (MEM/WB control fields concatenated).
REQ-003 SHALL have parameter CTRL_BUBBLE, default all-zero, control value driven for a bubble; it SHALL be a no-op (no regwr, no memwr, no branch, no jump).
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 validin  input  1  upstream stage holds a real instruction.
REQ-008 datain  input  DWIDTH  datapath payload from upstream.
REQ-009 ctrlin  input  CWIDTH  control payload from upstream.
REQ-010 stall  input  1  hold the current contents (hazard unit).
REQ-011 flush  input  1  replace the contents with a bubble (branch/jump taken).
REQ-012 validout  output  1  registered valid.
REQ-013 dataout  output  DWIDTH  registered datapath payload.
REQ-014 ctrlout  output  CWIDTH  registered control payload.

Function
REQ-015 SHALL drive all outputs directly from flops, with no combinational path from any input to any output.
REQ-016 SHALL apply the priority rst > flush > stall > load at every rising clk edge.
REQ-017 Load (no rst, flush or stall): validout<=validin, dataout<=datain; ctrlout<=ctrlin if validin=1, else CTRL_BUBBLE; latency is 1 cycle.
REQ-018 Stall (no rst or flush): validout, dataout and ctrlout SHALL hold their values for every cycle stall=1, with no limit on stall length.
REQ-019 Flush (no rst): validout<=0, ctrlout<=CTRL_BUBBLE, dataout holds; this applies even when stall=1 in the same cycle.
REQ-020 Leaving stall SHALL load the current inputs on the first edge with stall=0; no stale or duplicated instruction.
REQ-021 Invariant: validout=0 implies ctrlout=CTRL_BUBBLE.

Reset
REQ-022 rst=1 at an edge: validout<=0, ctrlout<=CTRL_BUBBLE, dataout<=0; this overrides flush, stall and load.
REQ-023 Reset mid-stall SHALL discard the held contents; the first edge after rst deasserts SHALL load normally.

Configuration
REQ-024 Macro PIPEREG_STATS_EN, when defined, SHALL add ports clrcnt (input, 1) and bubblecnt (output, 16).
REQ-025 With PIPEREG_STATS_EN defined: bubblecnt SHALL increment by 1 at each edge where validout=0 (value before the edge) and saturate at 16'hFFFF.
REQ-026 With PIPEREG_STATS_EN defined: rst or clrcnt SHALL set bubblecnt to 0, and clear SHALL win over increment in the same cycle.
REQ-027 Without PIPEREG_STATS_EN: the ports and counter logic SHALL be absent, and behaviour SHALL be identical to REQ-015..023.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the default CTRL_BUBBLE and the constant STATCNT_WIDTH=16.
REQ-029 The counter SHALL be sub-module pipe_statcnt (clk, rst, clr, inc, count), instantiated only under PIPEREG_STATS_EN.
REQ-030 Instances replacing the fixed-width stage registers SHALL differ only in DWIDTH/CWIDTH.

Verification
REQ-031 rst=1 for 2 cycles, then rst=0 with validin=0 -> validout=0, ctrlout=CTRL_BUBBLE, dataout=0.
REQ-032 validin=1, datain=32'hDEADBEEF, ctrlin=8'hA5 at edge N -> outputs show the same values after edge N, unchanged after edge N-1.
REQ-033 Load 32'h11111111, then stall=1 for 3 cycles while datain=32'h22222222 -> dataout stays 32'h11111111; after stall drops, 32'h22222222 appears one edge later.
REQ-034 stall=1 and flush=1 together with ctrlin=8'hFF, validin=1 -> validout=0 and ctrlout=CTRL_BUBBLE after the edge.
REQ-035 validin=0 with ctrlin=8'h3C -> ctrlout=CTRL_BUBBLE and validout=0.
REQ-036 PIPEREG_STATS_EN, 70000 bubble cycles -> bubblecnt=16'hFFFF; clrcnt=1 for one cycle -> 0; clrcnt=1 with validout=0 -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants, types and helpers for the pipeline stage
//                register and its optional bubble statistics counter.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Width of the bubble statistics counter.
  localparam int STATCNT_WIDTH = 16;

  // Default bubble control word: all-zero means no regwr/memwr/branch/jump.
  localparam logic [63:0] CTRL_BUBBLE_DEFAULT = 64'd0;

  // Action taken by the stage register at the next edge (rst handled apart).
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STALL = 2'd1,
    OP_FLUSH = 2'd2
  } stage_op_e;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [STATCNT_WIDTH-1:0] sat_inc(
    input logic [STATCNT_WIDTH-1:0] v
  );
    return (v == {STATCNT_WIDTH{1'b1}}) ? v : v + STATCNT_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipereg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipereg_if
//  Description : Stage-register bundle: upstream payload plus hazard-unit
//                controls in, registered payload out.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipereg_if #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 8
);
  logic              validin;
  logic [DWIDTH-1:0] datain;
  logic [CWIDTH-1:0] ctrlin;
  logic              stall;
  logic              flush;
  logic              validout;
  logic [DWIDTH-1:0] dataout;
  logic [CWIDTH-1:0] ctrlout;

  // Upstream / hazard-unit side.
  modport master (
    output validin, datain, ctrlin, stall, flush,
    input  validout, dataout, ctrlout
  );

  // Stage register side.
  modport slave (
    input  validin, datain, ctrlin, stall, flush,
    output validout, dataout, ctrlout
  );
endinterface
`default_nettype wire

// File: rtl/pipe_statcnt.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_statcnt
//  Description : Saturating event counter with synchronous clear; clear wins
//                over increment.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_statcnt
  import pipe_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [STATCNT_WIDTH-1:0] count
);

  logic [STATCNT_WIDTH-1:0] r_count;

  // Count events, saturating at all-ones; reset and clear both zero it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipereg.sv
`default_nettype none
// ============================================================================
//  Module      : pipereg
//  Description : Generic pipeline stage register with valid, stall and flush.
//                Priority at each edge: rst > flush > stall > load. Outputs
//                come straight from flops. An invalid slot always carries the
//                bubble control word.
//                Optional macro PIPEREG_STATS_EN adds clrcnt/bubblecnt, a
//                saturating count of edges at which the stage held a bubble.
//  Revision    : 1.0  initial release
// ============================================================================
module pipereg
  import pipe_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter int                CWIDTH      = 8,
  parameter logic [CWIDTH-1:0] CTRL_BUBBLE = CWIDTH'(CTRL_BUBBLE_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef PIPEREG_STATS_EN
  input  logic                     clrcnt,
  output logic [STATCNT_WIDTH-1:0] bubblecnt,
`endif
  pipereg_if.slave                 bus
);

  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic [CWIDTH-1:0] r_ctrl;
  stage_op_e         w_op;

  // Decode the hazard controls; flush beats stall.
  always_comb begin
    w_op = OP_LOAD;
    if (bus.flush) begin
      w_op = OP_FLUSH;
    end else if (bus.stall) begin
      w_op = OP_STALL;
    end
  end

  // Stage register: reset clears everything, flush kills the slot but keeps
  // the data bits, stall holds, load takes the upstream values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= CTRL_BUBBLE;
    end else begin
      unique case (w_op)
        OP_FLUSH: begin
          r_valid <= 1'b0;
          r_ctrl  <= CTRL_BUBBLE;
        end
        OP_STALL: begin
          r_valid <= r_valid;
          r_data  <= r_data;
          r_ctrl  <= r_ctrl;
        end
        default: begin
          r_valid <= bus.validin;
          r_data  <= bus.datain;
          r_ctrl  <= bus.validin ? bus.ctrlin : CTRL_BUBBLE;
        end
      endcase
    end
  end

  assign bus.validout = r_valid;
  assign bus.dataout  = r_data;
  assign bus.ctrlout  = r_ctrl;

`ifdef PIPEREG_STATS_EN
  pipe_statcnt u_statcnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clrcnt),
    .inc   (~r_valid),
    .count (bubblecnt)
  );
`else
  // No statistics hardware in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipereg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pipereg
//  Description : Self-checking bench for pipereg (DWIDTH=32, CWIDTH=8).
//                Counter checks are built when PIPEREG_STATS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipereg;

  localparam logic [7:0]  c_bubble = 8'h00;
  localparam logic [15:0] c_cntmax = 16'hFFFF;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [7:0]  c;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic clrcnt;
  logic [15:0] bubblecnt;

  pipereg_if #(.DWIDTH(32), .CWIDTH(8)) bus ();

  pipereg #(.DWIDTH(32), .CWIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPEREG_STATS_EN
    .clrcnt    (clrcnt),
    .bubblecnt (bubblecnt),
`endif
    .bus       (bus)
  );

`ifndef PIPEREG_STATS_EN
  assign bubblecnt = 16'h0000;
`endif

  always #5 clk = ~clk;

  obs_t        sb[$];
  obs_t        m;
  logic [15:0] m_cnt;
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference behaviour of one edge.
  function automatic obs_t model_next(obs_t cur, logic r, logic fl, logic st,
                                      logic v, logic [31:0] d, logic [7:0] c);
    obs_t o;
    o = cur;
    if (r) begin
      o.v = 1'b0; o.d = 32'h0; o.c = c_bubble;
    end else if (fl) begin
      o.v = 1'b0; o.c = c_bubble;
    end else if (!st) begin
      o.v = v; o.d = d; o.c = v ? c : c_bubble;
    end
    return o;
  endfunction

  // Apply inputs for the coming edge and push the expected result.
  task automatic drive(input logic r, input logic fl, input logic st,
                       input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic clr);
    rst         = r;
    clrcnt      = clr;
    bus.flush   = fl;
    bus.stall   = st;
    bus.validin = v;
    bus.datain  = d;
    bus.ctrlin  = c;
    if (r || clr) m_cnt = 16'h0;
    else if (!m.v && m_cnt != c_cntmax) m_cnt = m_cnt + 16'h1;
    m = model_next(m, r, fl, st, v, d, c);
    sb.push_back(m);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.v = bus.validout; o.d = bus.dataout; o.c = bus.ctrlout;
    return o;
  endfunction

  task automatic test_reset();
    obs_t exp, got;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, i[0], 1'b0, 1'b1, $urandom, 8'hFF, 1'b0);
      else       drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
      tick();
      exp = sb.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
                 i, got.v, got.d, got.c, exp.v, exp.d, exp.c);
      end
    end
  endtask

  task automatic test_load();
    obs_t exp, got, prev;
    logic [31:0] d_tab [4] = '{32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF, 32'h5A5A0F0F};
    logic [7:0]  c_tab [4] = '{8'hA5, 8'h01, 8'hFF, 8'h7E};
    for (int i = 0; i < 4; i++) begin
      prev = m;
      drive(1'b0, 1'b0, 1'b0, 1'b1, d_tab[i], c_tab[i], 1'b0);
      // Before the edge the outputs must still show the previous slot.
      got = observe();
      n_cmp++;
      if (got !== prev) begin
        n_fail++;
        $display("FAIL load_pre[%0d]: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
                 i, got.v, got.d, got.c, prev.v, prev.d, prev.c);
      end
      tick();
      exp = sb.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load[%0d]: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
                 i, got.v, got.d, got.c, exp.v, exp.d, exp.c);
      end
    end
  endtask

  task automatic test_invalid_ctrl();
    obs_t exp, got;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 8'h3C, 1'b0);
    tick();
    exp = sb.pop_front();
    got = observe();
    n_cmp++;
    if (got !== exp || got.c !== c_bubble) begin
      n_fail++;
      $display("FAIL invalid_ctrl: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
               got.v, got.d, got.c, exp.v, exp.d, exp.c);
    end
  endtask

  task automatic test_stall();
    obs_t exp, got;
    // Load, stall three cycles with new data waiting, release, then idle.
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 8'h21, 1'b0);
        1, 2, 3: drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h22222222, 8'h42, 1'b0);
        4:       drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 8'h42, 1'b0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 8'h63, 1'b0);
      endcase
      tick();
      exp = sb.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
                 i, got.v, got.d, got.c, exp.v, exp.d, exp.c);
      end
    end
  endtask

  task automatic test_flush();
    obs_t exp, got;
    // Flush together with stall, flush alone, then a recovery load.
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h44444444, 8'h5A, 1'b0);
        1: drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h55555555, 8'hFF, 1'b0);
        2: drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h66666666, 8'hFF, 1'b0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777, 8'h99, 1'b0);
      endcase
      tick();
      exp = sb.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL flush[%0d]: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
                 i, got.v, got.d, got.c, exp.v, exp.d, exp.c);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t exp, got;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555, 8'h3F, 1'b0);
        1:    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hBBBBBBBB, 8'h11, 1'b0);
        2:    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hBBBBBBBB, 8'h11, 1'b0);
        3:    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 8'h81, 1'b0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
      endcase
      tick();
      exp = sb.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rst_mid_stall[%0d]: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
                 i, got.v, got.d, got.c, exp.v, exp.d, exp.c);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp, got;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), $urandom, 8'($urandom), 1'b0);
      tick();
      exp = sb.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%0b d=%h c=%h expected v=%0b d=%h c=%h",
                 i, got.v, got.d, got.c, exp.v, exp.d, exp.c);
      end
      if (!got.v) begin
        n_cmp++;
        if (got.c !== c_bubble) begin
          n_fail++;
          $display("FAIL b2b_invariant[%0d]: got c=%h expected c=%h", i, got.c, c_bubble);
        end
      end
    end
  endtask

`ifdef PIPEREG_STATS_EN
  task automatic test_stats();
    obs_t exp;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);  // clear
        1: begin                                                // long bubble run
          for (int k = 0; k < 70000; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
            tick();
            exp = sb.pop_front();
          end
        end
        2: drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);  // clear vs inc
        default: drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
      endcase
      if (i != 1) begin
        tick();
        exp = sb.pop_front();
      end
      n_cmp++;
      if (bubblecnt !== m_cnt) begin
        n_fail++;
        $display("FAIL stats[%0d]: got bubblecnt=%h expected %h", i, bubblecnt, m_cnt);
      end
    end
    n_cmp++;
    if (m_cnt !== 16'h0001) begin
      n_fail++;
      $display("FAIL stats_model: got %h expected 0001", m_cnt);
    end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m      = '0;
    m_cnt  = 16'h0;
    rst    = 1'b1;
    clrcnt = 1'b0;
    test_reset();
    test_load();
    test_invalid_ctrl();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef PIPEREG_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
